// File: rtl/muldiv_iter_unit_pkg.sv
// muldiv_iter_unit_pkg: shared state/op encodings and constants for the iterative mul/div unit
package muldiv_iter_unit_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_e;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
  localparam logic [63:0] DIV0_QUOTIENT = '1;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring shift-subtract divide iteration
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  input  logic              op_div,
  output logic [2*XLEN-1:0] acc_o
);
  logic [XLEN:0] sum, diff;
  // mul: {hi,lo} with multiplier in lo, add on lsb then shift right; div: {rem,dividend} shift left, subtract if it fits
  always_comb begin
    sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    diff  = acc_i[2*XLEN-1:XLEN-1] - {1'b0, opnd_i};
    acc_o = !op_div ? {sum, acc_i[XLEN-1:1]} :
            diff[XLEN] ? {acc_i[2*XLEN-2:0], 1'b0} :
            {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
  end
endmodule

// File: rtl/muldiv_iter_unit.sv
// muldiv_iter_unit: iterative mul/div owning HI/LO; MULDIV_SIGNED_EN enables signed ops
module muldiv_iter_unit
  import muldiv_iter_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            op_div,
  input  logic            is_signed,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cancel,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero
);
  localparam int CW = $clog2(XLEN / UNROLL + 1);
  state_e            state_q, state_d;
  logic [2*XLEN-1:0] acc_q, acc_d, prod;
  logic [XLEN-1:0]   opb_q, opb_d, hi_q, hi_d, lo_q, lo_d, a_mag, b_mag, quo, rem;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              op_q, op_d, dz_q, dz_d, done_q, done_d, dzo_q, dzo_d, launch;
  logic [2*XLEN-1:0] chain [UNROLL+1];
  assign launch = state_q == IDLE && start && !cancel;
  assign chain[0] = acc_q;
  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .acc_i (chain[i]),
      .opnd_i(opb_q),
      .op_div(op_q),
      .acc_o (chain[i+1])
    );
  end
`ifdef MULDIV_SIGNED_EN
  logic neg_q, neg_d, rneg_q, rneg_d, sa, sb;
  assign sa    = is_signed & a[XLEN-1];
  assign sb    = is_signed & b[XLEN-1];
  assign a_mag = sa ? -a : a;
  assign b_mag = sb ? -b : b;
  assign prod  = neg_q ? -acc_q : acc_q;
  assign quo   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem   = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  // result sign flags captured at launch: product/quotient sign, remainder follows dividend
  always_comb begin
    neg_d  = launch ? sa ^ sb : neg_q;
    rneg_d = launch ? sa : rneg_q;
  end
  // sign flag registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
    end
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign a_mag = a;
  assign b_mag = b;
  assign prod  = acc_q;
  assign quo   = acc_q[XLEN-1:0];
  assign rem   = acc_q[2*XLEN-1:XLEN];
`endif
  // control: launch from IDLE, iterate in RUN, commit sign-fixed result in FIX; cancel aborts silently
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dzo_d   = 1'b0;
    if (state_q == IDLE) begin
      hi_d = hi_we ? wdata : hi_q;
      lo_d = lo_we ? wdata : lo_q;
      if (launch) begin
        state_d = RUN;
        op_d    = op_div;
        acc_d   = {{XLEN{1'b0}}, op_div ? a_mag : b_mag};
        opb_d   = op_div ? b_mag : a_mag;
        cnt_d   = CW'(XLEN / UNROLL);
        dz_d    = op_div && b == '0;
      end
    end else if (cancel) begin
      state_d = IDLE;
    end else if (state_q == RUN) begin
      acc_d   = chain[UNROLL];
      cnt_d   = cnt_q - CW'(1);
      state_d = cnt_q == CW'(1) ? FIX : RUN;
    end else begin
      state_d = IDLE;
      done_d  = 1'b1;
      dzo_d   = dz_q;
      hi_d    = op_q == OP_DIV ? rem : prod[2*XLEN-1:XLEN];
      lo_d    = op_q == OP_MUL ? prod[XLEN-1:0] : dz_q ? DIV0_QUOTIENT[XLEN-1:0] : quo;
    end
  end
  // state and datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dzo_q   <= dzo_d;
    end
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = state_q != IDLE;
  assign done        = done_q;
  assign div_by_zero = dzo_q;
endmodule

// File: tb/tb_muldiv_iter_unit.sv
// tb_muldiv_iter_unit: directed and random checks of muldiv_iter_unit against an arithmetic model
module tb_muldiv_iter_unit;
`ifdef MULDIV_SIGNED_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start1 = 1'b0, start4 = 1'b0, op_div = 1'b0, is_signed = 1'b0;
  logic cancel = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic [31:0] hi1, lo1, hi4, lo4;
  logic busy1, done1, dz1, busy4, done4, dz4;
  logic [31:0] eh1 = '0, el1 = '0, eh4 = '0, el4 = '0;
  int npass = 0, nfail = 0, total = 0;

  always #5 clk = ~clk;

  muldiv_iter_unit #(.XLEN(32), .UNROLL(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .op_div(op_div), .is_signed(is_signed), .a(a), .b(b),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .hi(hi1), .lo(lo1),
    .busy(busy1), .done(done1), .div_by_zero(dz1));
  muldiv_iter_unit #(.XLEN(32), .UNROLL(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .op_div(op_div), .is_signed(is_signed), .a(a), .b(b),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .hi(hi4), .lo(lo4),
    .busy(busy4), .done(done4), .div_by_zero(dz4));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input bit dv, input bit sg, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l, output bit dz);
    longint sx, sy, p, q, r;
    bit s;
    s  = sg && SGN_EN;
    sx = s ? longint'(signed'(x)) : longint'({32'b0, x});
    sy = s ? longint'(signed'(y)) : longint'({32'b0, y});
    dz = dv && y == 0;
    if (!dv) begin
      p = sx * sy;
      h = p[63:32];
      l = p[31:0];
    end else if (y == 0) begin
      h = x;
      l = 32'hFFFFFFFF;
    end else begin
      q = sx / sy;
      r = sx % sy;
      h = r[31:0];
      l = q[31:0];
    end
  endfunction

  task automatic run(input bit w4, input bit dv, input bit sg, input logic [31:0] x, input logic [31:0] y,
                     input int extra, input string tag);
    logic [31:0] h, l;
    bit edz, dzbad;
    int k;
    model(dv, sg, x, y, h, l, edz);
    @(negedge clk);
    op_div = dv; is_signed = sg; a = x; b = y;
    if (w4) start4 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    check({tag, "_busy"}, w4 ? busy4 : busy1, 1);
    k = 0;
    dzbad = 0;
    while (!(w4 ? done4 : done1) && k < 200) begin
      if (k == extra) begin
        if (w4) start4 = 1'b1; else start1 = 1'b1;
        a = ~x; b = x;
      end else begin
        start1 = 1'b0; start4 = 1'b0;
      end
      @(negedge clk);
      k++;
      if ((w4 ? dz4 : dz1) && !(w4 ? done4 : done1)) dzbad = 1;
    end
    start1 = 1'b0; start4 = 1'b0;
    check({tag, "_lat"}, k, w4 ? 9 : 33);
    check({tag, "_busy_done"}, w4 ? busy4 : busy1, 0);
    check({tag, "_hilo"}, w4 ? {hi4, lo4} : {hi1, lo1}, {h, l});
    check({tag, "_dz"}, {dzbad, w4 ? dz4 : dz1}, {1'b0, edz});
    if (w4) begin eh4 = h; el4 = l; end else begin eh1 = h; el1 = l; end
    @(negedge clk);
    check({tag, "_pulse"}, w4 ? {done4, dz4} : {done1, dz1}, 0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    return $urandom_range(3) == 0 ? sp[$urandom_range(4)] : $urandom;
  endfunction

  initial begin
    logic [31:0] sh, sl;
    bit sdz, bad;
    #1;
    check("rst_u1", {hi1, lo1, busy1, done1, dz1}, 0);
    check("rst_u4", {hi4, lo4, busy4, done4, dz4}, 0);
    @(negedge clk);
    rst = 1'b0;
    run(0, 0, 1, 32'd7, 32'hFFFFFFFD, -1, "smul");
    run(0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, "umul");
    run(1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, "umul4");
    run(0, 1, 1, 32'hFFFFFFF9, 32'd2, -1, "sdiv");
    run(0, 1, 1, 32'h80000000, 32'hFFFFFFFF, -1, "minneg");
    run(0, 1, 0, 32'd5, 32'd0, -1, "div0");
    run(1, 1, 1, 32'hFFFFFFFB, 32'd0, -1, "div0s4");
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h0;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    lo_we = 1'b0;
    check("preload", {hi1, lo1}, {32'h0, 32'h1234});
    op_div = 1'b0; is_signed = 1'b0; a = 32'd3; b = 32'd4; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", busy1, 0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (done1 || busy1) bad = 1;
    end
    check("cancel_quiet", bad, 0);
    check("cancel_hilo", {hi1, lo1}, {32'h0, 32'h1234});
    run(0, 0, 1, 32'h00012345, 32'hFFFF0001, 5, "restart");
    run(1, 1, 0, 32'd1000, 32'd7, 3, "restart4");
    for (int i = 0; i < 12; i++) begin
      run(0, 1'($urandom_range(1)), 1'($urandom_range(1)), pick(), pick(), -1, $sformatf("rnd1_%0d", i));
      run(1, 1'($urandom_range(1)), 1'($urandom_range(1)), pick(), pick(), -1, $sformatf("rnd4_%0d", i));
    end
    model(0, 0, 32'd9, 32'd9, sh, sl, sdz);
    @(negedge clk);
    op_div = 1'b0; is_signed = 1'b0; a = 32'hFFFF; b = 32'hFFFF; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_mid", {hi1, lo1, busy1, done1, dz1}, 0);
    @(negedge clk);
    rst = 1'b0;
    run(0, 0, 0, 32'd9, 32'd9, -1, "after_rst");
    check("after_rst_model", {hi1, lo1}, {sh, sl});
    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end
endmodule
